reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 25 ++
 rtl/reorder_buffer.sv | 139 +++++++++++++
 tb/tb_reorder_buffer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry layout for the 16-entry reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_SIZE      = 16;
    localparam int ROB_TAG_WIDTH = 4;
    localparam int REG_TAG_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    typedef struct packed {
        logic                     busy;
        logic                     ready;
        logic [REG_TAG_WIDTH-1:0] dest_reg;
        logic [DATA_WIDTH-1:0]    value;
        logic                     is_branch;
        logic                     is_store;
        logic                     mispredict;
        logic [DATA_WIDTH-1:0]    target_pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, completes via CDB, commits from head,
// and flushes everything when a mispredicted branch reaches the head.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     in_decode_valid,
    input  logic [REG_TAG_WIDTH-1:0] in_decode_dest_reg,
    input  logic                     in_decode_is_branch,
    input  logic                     in_decode_is_store,
    output logic [ROB_TAG_WIDTH-1:0] out_decode_rob_tag,
    output logic                     out_rob_full,
    input  logic [ROB_TAG_WIDTH-1:0] in_decode_query_tag1,
    input  logic [ROB_TAG_WIDTH-1:0] in_decode_query_tag2,
    output logic                     out_query_ready1,
    output logic                     out_query_ready2,
    output logic [DATA_WIDTH-1:0]    out_query_value1,
    output logic [DATA_WIDTH-1:0]    out_query_value2,
    input  logic                     in_cdb_valid,
    input  logic [ROB_TAG_WIDTH-1:0] in_cdb_tag,
    input  logic [DATA_WIDTH-1:0]    in_cdb_value,
    input  logic                     in_cdb_mispredict,
    input  logic [DATA_WIDTH-1:0]    in_cdb_target_pc,
    output logic [REG_TAG_WIDTH-1:0] out_commit_reg,
    output logic [ROB_TAG_WIDTH-1:0] out_commit_rob,
    output logic [DATA_WIDTH-1:0]    out_commit_value,
    output logic                     out_store_commit,
    output logic                     out_flush,
    output logic [DATA_WIDTH-1:0]    out_flush_pc
);

    rob_entry_t entries [ROB_SIZE];

    logic [ROB_TAG_WIDTH-1:0] head;
    logic [ROB_TAG_WIDTH-1:0] tail;
    logic [ROB_TAG_WIDTH:0]   count;
    logic [ROB_TAG_WIDTH:0]   count_next;

    logic do_commit;
    logic do_flush;
    logic do_alloc;
    logic do_writeback;

    // Commit only looks at registered ready, so a CDB write to the head retires a cycle later.
    assign do_commit    = rdy && (count != '0) && entries[head].ready;
    assign do_flush     = do_commit && entries[head].is_branch && entries[head].mispredict;
    assign do_alloc     = rdy && in_decode_valid && !out_rob_full && !do_flush;
    assign do_writeback = rdy && in_cdb_valid && entries[in_cdb_tag].busy && !do_flush;

    assign count_next = count + (ROB_TAG_WIDTH+1)'(do_alloc) - (ROB_TAG_WIDTH+1)'(do_commit);

    assign out_rob_full       = (count == (ROB_TAG_WIDTH+1)'(ROB_SIZE));
    assign out_decode_rob_tag = tail;

    // Operand lookups see a result being broadcast this very cycle.
    always_comb begin
        out_query_ready1 = entries[in_decode_query_tag1].ready;
        out_query_value1 = entries[in_decode_query_tag1].value;
        out_query_ready2 = entries[in_decode_query_tag2].ready;
        out_query_value2 = entries[in_decode_query_tag2].value;
        if (in_cdb_valid && (in_cdb_tag == in_decode_query_tag1)) begin
            out_query_ready1 = TRUE;
            out_query_value1 = in_cdb_value;
        end
        if (in_cdb_valid && (in_cdb_tag == in_decode_query_tag2)) begin
            out_query_ready2 = TRUE;
            out_query_value2 = in_cdb_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            out_commit_reg   <= '0;
            out_commit_rob   <= '0;
            out_commit_value <= ZERO_DATA;
            out_store_commit <= FALSE;
            out_flush        <= FALSE;
            out_flush_pc     <= ZERO_DATA;
        end else begin
            out_commit_reg   <= '0;
            out_store_commit <= FALSE;
            out_flush        <= FALSE;
            if (do_flush) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries[i].busy  <= FALSE;
                    entries[i].ready <= FALSE;
                end
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                out_flush    <= TRUE;
                out_flush_pc <= entries[head].target_pc;
            end else if (rdy) begin
                if (do_writeback) begin
                    entries[in_cdb_tag].ready      <= TRUE;
                    entries[in_cdb_tag].value      <= in_cdb_value;
                    entries[in_cdb_tag].mispredict <= in_cdb_mispredict;
                    entries[in_cdb_tag].target_pc  <= in_cdb_target_pc;
                end
                // Stores and correctly predicted branches retire without a register write.
                if (do_commit) begin
                    entries[head].busy  <= FALSE;
                    entries[head].ready <= FALSE;
                    head                <= head + 1'b1;
                    if (entries[head].is_store) begin
                        out_store_commit <= TRUE;
                        out_commit_rob   <= head;
                        out_commit_value <= entries[head].value;
                    end else if (!entries[head].is_branch) begin
                        out_commit_reg   <= entries[head].dest_reg;
                        out_commit_rob   <= head;
                        out_commit_value <= entries[head].value;
                    end
                end
                if (do_alloc) begin
                    entries[tail].busy       <= TRUE;
                    entries[tail].ready      <= FALSE;
                    entries[tail].dest_reg   <= in_decode_dest_reg;
                    entries[tail].value      <= ZERO_DATA;
                    entries[tail].is_branch  <= in_decode_is_branch;
                    entries[tail].is_store   <= in_decode_is_store;
                    entries[tail].mispredict <= FALSE;
                    entries[tail].target_pc  <= ZERO_DATA;
                    tail                     <= tail + 1'b1;
                end
                count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table plus hand-written
// sequences for ordering, full, mispredict flush, stall and mid-flight reset.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_decode_valid;
    logic [4:0]  in_decode_dest_reg;
    logic        in_decode_is_branch;
    logic        in_decode_is_store;
    logic [3:0]  out_decode_rob_tag;
    logic        out_rob_full;
    logic [3:0]  in_decode_query_tag1;
    logic [3:0]  in_decode_query_tag2;
    logic        out_query_ready1;
    logic        out_query_ready2;
    logic [31:0] out_query_value1;
    logic [31:0] out_query_value2;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_tag;
    logic [31:0] in_cdb_value;
    logic        in_cdb_mispredict;
    logic [31:0] in_cdb_target_pc;
    logic [4:0]  out_commit_reg;
    logic [3:0]  out_commit_rob;
    logic [31:0] out_commit_value;
    logic        out_store_commit;
    logic        out_flush;
    logic [31:0] out_flush_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    reorder_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .in_decode_valid     (in_decode_valid),
        .in_decode_dest_reg  (in_decode_dest_reg),
        .in_decode_is_branch (in_decode_is_branch),
        .in_decode_is_store  (in_decode_is_store),
        .out_decode_rob_tag  (out_decode_rob_tag),
        .out_rob_full        (out_rob_full),
        .in_decode_query_tag1(in_decode_query_tag1),
        .in_decode_query_tag2(in_decode_query_tag2),
        .out_query_ready1    (out_query_ready1),
        .out_query_ready2    (out_query_ready2),
        .out_query_value1    (out_query_value1),
        .out_query_value2    (out_query_value2),
        .in_cdb_valid        (in_cdb_valid),
        .in_cdb_tag          (in_cdb_tag),
        .in_cdb_value        (in_cdb_value),
        .in_cdb_mispredict   (in_cdb_mispredict),
        .in_cdb_target_pc    (in_cdb_target_pc),
        .out_commit_reg      (out_commit_reg),
        .out_commit_rob      (out_commit_rob),
        .out_commit_value    (out_commit_value),
        .out_store_commit    (out_store_commit),
        .out_flush           (out_flush),
        .out_flush_pc        (out_flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [4:0]  dreg;
        logic        br;
        logic        st;
        logic [3:0]  q;
        logic        cv;
        logic [3:0]  ctag;
        logic [31:0] cval;
        logic        mis;
        logic [31:0] tpc;
        logic [3:0]  e_tag;
        logic        e_full;
        logic        e_qr;
        logic [31:0] e_qv;
        logic [4:0]  e_creg;
        logic [3:0]  e_crob;
        logic [31:0] e_cval;
        logic        e_store;
        logic        e_flush;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [4:0] dreg, input logic br, input logic st,
                         input logic cv, input logic [3:0] ctag, input logic [31:0] cval,
                         input logic mis, input logic [31:0] tpc);
        in_decode_valid     = dv;
        in_decode_dest_reg  = dreg;
        in_decode_is_branch = br;
        in_decode_is_store  = st;
        in_cdb_valid        = cv;
        in_cdb_tag          = ctag;
        in_cdb_value        = cval;
        in_cdb_mispredict   = mis;
        in_cdb_target_pc    = tpc;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.dv, v.dreg, v.br, v.st, v.cv, v.ctag, v.cval, v.mis, v.tpc);
        in_decode_query_tag1 = v.q;
        in_decode_query_tag2 = v.q;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    logic [31:0] ooo_vals [3];

    initial begin
        // dv dreg br st q | cv ctag cval mis tpc | tag full qr qv | creg crob cval store flush fpc
        vecs[0] = '{1, 5, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0};
        vecs[1] = '{0, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, 32'h0,  1, 0, 1, 32'h12345678, 0, 0, 32'h0,        0, 0, 32'h0};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0,  1, 0, 1, 32'h12345678, 5, 0, 32'h12345678, 0, 0, 32'h0};
        vecs[3] = '{1, 7, 0, 1, 1, 0, 0, 32'h0,        0, 32'h0,  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0};
        vecs[4] = '{1, 0, 1, 0, 2, 1, 1, 32'hAA,       0, 32'h0,  2, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0};
        vecs[5] = '{1, 9, 0, 0, 1, 1, 2, 32'h0,        0, 32'h40, 3, 0, 1, 32'hAA,       0, 0, 32'h0,        1, 0, 32'h0};
        vecs[6] = '{0, 0, 0, 0, 3, 1, 3, 32'hDEADBEEF, 0, 32'h0,  4, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'h0};
        vecs[7] = '{0, 0, 0, 0, 3, 0, 0, 32'h0,        0, 32'h0,  4, 0, 1, 32'hDEADBEEF, 9, 3, 32'hDEADBEEF, 0, 0, 32'h0};
        vecs[8] = '{0, 0, 0, 0, 5, 1, 5, 32'h55,       0, 32'h0,  4, 0, 1, 32'h55,       0, 0, 32'h0,        0, 0, 32'h0};
        vecs[9] = '{0, 0, 0, 0, 5, 0, 0, 32'h0,        0, 32'h0,  4, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0};
        ooo_vals = '{32'h10, 32'h11, 32'h22};

        rst = 1'b0;
        rdy = 1'b1;
        in_decode_query_tag1 = 0;
        in_decode_query_tag2 = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("reset_commit_reg", out_commit_reg, 0);
        checkOutput("reset_store", out_store_commit, 0);
        checkOutput("reset_flush", out_flush, 0);
        checkOutput("reset_tag", out_decode_rob_tag, 0);
        checkOutput("reset_full", out_rob_full, 0);
        rst = 1'b1;

        // Table: pre-edge combinational checks, then registered checks after the edge
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_tag", i), out_decode_rob_tag, vecs[i].e_tag);
            checkOutput($sformatf("v%0d_full", i), out_rob_full, vecs[i].e_full);
            checkOutput($sformatf("v%0d_qready1", i), out_query_ready1, vecs[i].e_qr);
            checkOutput($sformatf("v%0d_qvalue1", i), out_query_value1, vecs[i].e_qv);
            checkOutput($sformatf("v%0d_qready2", i), out_query_ready2, vecs[i].e_qr);
            checkOutput($sformatf("v%0d_qvalue2", i), out_query_value2, vecs[i].e_qv);
            tick();
            checkOutput($sformatf("v%0d_commit_reg", i), out_commit_reg, vecs[i].e_creg);
            checkOutput($sformatf("v%0d_store", i), out_store_commit, vecs[i].e_store);
            checkOutput($sformatf("v%0d_flush", i), out_flush, vecs[i].e_flush);
            if (vecs[i].e_creg != 0) begin
                checkOutput($sformatf("v%0d_commit_rob", i), out_commit_rob, vecs[i].e_crob);
                checkOutput($sformatf("v%0d_commit_value", i), out_commit_value, vecs[i].e_cval);
            end
            if (vecs[i].e_flush) begin
                checkOutput($sformatf("v%0d_flush_pc", i), out_flush_pc, vecs[i].e_fpc);
            end
        end

        // Out-of-order completion retires strictly in order on consecutive cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 2, 32'h22, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 1, 32'h11, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 32'h10, 0, 0); tick();
        checkOutput("ooo_no_same_cycle_commit", out_commit_reg, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("ooo_reg%0d", k), out_commit_reg, 32'(k + 1));
            checkOutput($sformatf("ooo_rob%0d", k), out_commit_rob, 32'(k));
            checkOutput($sformatf("ooo_val%0d", k), out_commit_value, ooo_vals[k]);
        end
        tick();
        checkOutput("ooo_drained", out_commit_reg, 0);

        // Fill to 16, ignore the 17th, then retire head and refill through the wrapped tail
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0);
            #1;
            checkOutput($sformatf("fill_tag%0d", i), out_decode_rob_tag, 32'(i));
            tick();
        end
        checkOutput("full_after16", out_rob_full, 1);
        checkOutput("full_tag_wrapped", out_decode_rob_tag, 0);
        drive(1, 31, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("full_17th_full", out_rob_full, 1);
        checkOutput("full_17th_tag", out_decode_rob_tag, 0);
        drive(1, 31, 0, 0, 1, 0, 32'h77, 0, 0);
        tick();
        checkOutput("full_wb_full", out_rob_full, 1);
        drive(1, 20, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("full_commit_reg", out_commit_reg, 1);
        checkOutput("full_commit_rob", out_commit_rob, 0);
        checkOutput("full_commit_val", out_commit_value, 32'h77);
        #1;
        checkOutput("refill_tag", out_decode_rob_tag, 0);
        tick();
        checkOutput("refill_full", out_rob_full, 1);
        checkOutput("refill_next_tag", out_decode_rob_tag, 1);

        // Mispredicted branch at head flushes younger ready entries and drops a same-cycle issue
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 1; i < 4; i++) begin
            drive(1, 5'(i), 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 4'(i), 32'(i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 0, 1, 32'h100);
        tick();
        checkOutput("mp_no_early_flush", out_flush, 0);
        drive(1, 30, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("mp_flush", out_flush, 1);
        checkOutput("mp_flush_pc", out_flush_pc, 32'h100);
        checkOutput("mp_flush_reg", out_commit_reg, 0);
        checkOutput("mp_tag_zero", out_decode_rob_tag, 0);
        checkOutput("mp_not_full", out_rob_full, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_decode_query_tag1 = 1;
        tick();
        checkOutput("mp_flush_pulse", out_flush, 0);
        checkOutput("mp_no_commit_a", out_commit_reg, 0);
        checkOutput("mp_query_cleared", out_query_ready1, 0);
        tick();
        checkOutput("mp_no_commit_b", out_commit_reg, 0);

        // rdy low freezes allocation and commit
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 32'h44, 0, 0); tick();
        rdy = 1'b0;
        drive(1, 6, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("stall_no_commit", out_commit_reg, 0);
        checkOutput("stall_no_alloc", out_decode_rob_tag, 1);
        tick();
        checkOutput("stall_no_commit2", out_commit_reg, 0);
        rdy = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("unstall_reg", out_commit_reg, 4);
        checkOutput("unstall_rob", out_commit_rob, 0);
        checkOutput("unstall_val", out_commit_value, 32'h44);
        rdy = 1'b0;
        tick();
        checkOutput("stall_pulse_drop", out_commit_reg, 0);
        rdy = 1'b1;

        // Asynchronous reset with entries in flight
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 1, 32'h99, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("pre_rst_reg", out_commit_reg, 1);
        checkOutput("pre_rst_val", out_commit_value, 32'h99);
        rst = 1'b0;
        #1;
        checkOutput("arst_reg", out_commit_reg, 0);
        checkOutput("arst_rob", out_commit_rob, 0);
        checkOutput("arst_val", out_commit_value, 0);
        checkOutput("arst_flush_pc", out_flush_pc, 0);
        checkOutput("arst_tag", out_decode_rob_tag, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0);
            #1;
            checkOutput($sformatf("post_rst_tag%0d", i), out_decode_rob_tag, 32'(i));
            checkOutput($sformatf("post_rst_full%0d", i), out_rob_full, 0);
            tick();
        end
        checkOutput("post_rst_full_end", out_rob_full, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
